mod_alu_arbiter: RTL and testbench

//  Time-shares one ModAdd/ModSub/ModMul/ModDiv datapath (operands mod `p, width `DATAWIDTH) among NREQ requesters.
//  - Round-robin arbitration; operands registered at grant.
//  - Results captured after a per-op settle count, so the deep ModMul/ModDiv cones run as multicycle paths.
//  - Sits between the EC point-arithmetic sequencers and the scalar field operators.

---
 rtl/mod_alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_mod_alu_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mod_alu_arbiter.sv
// Round-robin arbiter sharing one modular add/sub/mul/div datapath among NREQ requesters.
// Results are captured after a per-op settle count, so the mul/div cones are multicycle paths.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif
`ifndef MOD_P
`define MOD_P 251
`endif

module mod_alu_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADD_WAIT = 1,
  parameter int MUL_WAIT = 2,
  parameter int DIV_WAIT = 8,
  parameter int CW       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         op,
  input  logic [NREQ*`DATAWIDTH-1:0] a,
  input  logic [NREQ*`DATAWIDTH-1:0] b,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [`DATAWIDTH-1:0]     r,
  output logic                      err,
  output logic                      busy
);
  localparam int W  = `DATAWIDTH;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [W-1:0] P = W'(`MOD_P);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          r_state, w_nstate;
  logic [PW-1:0]   r_ptr, r_owner, w_sel;
  logic            w_hit;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a, r_b, r_r, w_res;
  logic [NREQ-1:0] r_gnt, r_done;
  logic            r_err;
  logic [1:0]      w_op_sel;

  function automatic logic [W-1:0] f_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(prod % {{W{1'b0}}, P});
  endfunction

  // Inverse by Fermat: x^(p-2) mod p; relies on `MOD_P being prime.
  function automatic logic [W-1:0] f_inv(input logic [W-1:0] x);
    logic [W-1:0] acc, base, e;
    acc  = W'(1);
    base = x;
    e    = P - W'(2);
    for (int k = 0; k < W; k++) begin
      if (e[k]) acc = f_mul(acc, base);
      base = f_mul(base, base);
    end
    return acc;
  endfunction

  function automatic logic [CW-1:0] f_wait(input logic [1:0] o);
    case (o)
      2'b10:   return CW'(MUL_WAIT);
      2'b11:   return CW'(DIV_WAIT);
      default: return CW'(ADD_WAIT);
    endcase
  endfunction

  // Scan from r_ptr upward, wrapping, for the first active request.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_hit && req[idx]) begin
        w_hit = 1'b1;
        w_sel = PW'(idx);
      end
    end
  end

  assign w_op_sel = op[2*w_sel +: 2];

  always_comb begin
    logic [W:0] t;
    t     = '0;
    w_res = '0;
    case (r_op)
      2'b00: begin
        t     = {1'b0, r_a} + {1'b0, r_b};
        w_res = (t >= {1'b0, P}) ? W'(t - {1'b0, P}) : t[W-1:0];
      end
      2'b01: begin
        t     = (r_a >= r_b) ? ({1'b0, r_a} - {1'b0, r_b})
                             : ({1'b0, r_a} + {1'b0, P} - {1'b0, r_b});
        w_res = t[W-1:0];
      end
      2'b10:   w_res = f_mul(r_a, r_b);
      default: w_res = (r_b == '0) ? '0 : f_mul(r_a, f_inv(r_b));
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_nstate = EXEC;
      EXEC:    if (r_cnt == CW'(1)) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_r     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_gnt   <= '0;
      r_done  <= '0;
      if (r_state == IDLE && w_hit) begin
        r_op         <= w_op_sel;
        r_a          <= a[W*w_sel +: W];
        r_b          <= b[W*w_sel +: W];
        r_gnt[w_sel] <= 1'b1;
        r_owner      <= w_sel;
        r_ptr        <= (int'(w_sel) == NREQ - 1) ? '0 : w_sel + PW'(1);
        r_cnt        <= f_wait(w_op_sel);
      end
      if (r_state == EXEC) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_r             <= w_res;
          r_err           <= (r_op == 2'b11) && (r_b == '0);
          r_done[r_owner] <= 1'b1;
        end
      end
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign r    = r_r;
  assign err  = r_err;
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_mod_alu_arbiter.sv
// Directed self-checking bench for mod_alu_arbiter (NREQ=2, 8-bit operands, p=251).
module tb_mod_alu_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [NREQ*W-1:0] a, b;
  logic [NREQ-1:0]   gnt, done;
  logic [W-1:0]      r;
  logic              err, busy;

  int total = 0;
  int bad   = 0;

  mod_alu_arbiter #(.NREQ(2), .ADD_WAIT(1), .MUL_WAIT(2), .DIV_WAIT(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .done(done), .r(r), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue one request and record the sample cycles of gnt and done (-1 on timeout).
  task automatic run_op(input int id, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int gc, output int dc, output logic [W-1:0] rr, output logic ee);
    int cyc;
    cyc = 0; gc = -1; dc = -1; rr = '0; ee = 1'b0;
    op[2*id +: 2] = o;
    a[W*id +: W]  = x;
    b[W*id +: W]  = y;
    req[id]       = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(); cyc++;
      if (gnt[id]) begin gc = cyc; break; end
    end
    req[id] = 1'b0;
    if (gc < 0) return;
    for (int k = 0; k < 40; k++) begin
      tick(); cyc++;
      if (done[id]) begin dc = cyc; rr = r; ee = err; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if ({gnt, done, busy, r, err} !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got gnt=%b done=%b busy=%b r=%0d err=%b want all 0", k, gnt, done, busy, r, err);
      end
    end
  endtask

  task automatic test_addsub();
    int gc, dc; logic [W-1:0] rr; logic ee;
    run_op(0, 2'b00, 8'd250, 8'd2, gc, dc, rr, ee);
    total++;
    if (gc !== 1 || dc !== 2) begin bad++; $display("FAIL add_timing got gnt@%0d done@%0d want 1,2", gc, dc); end
    total++;
    if (rr !== 8'd1 || ee !== 1'b0) begin bad++; $display("FAIL add_result got r=%0d err=%b want 1,0", rr, ee); end
    run_op(0, 2'b01, 8'd1, 8'd2, gc, dc, rr, ee);
    total++;
    if (dc - gc !== 1 || gc < 0) begin bad++; $display("FAIL sub_latency got %0d want 1", dc - gc); end
    total++;
    if (rr !== 8'd250 || ee !== 1'b0) begin bad++; $display("FAIL sub_result got r=%0d err=%b want 250,0", rr, ee); end
    tick(); tick();
    total++;
    if (r !== 8'd250) begin bad++; $display("FAIL r_hold got %0d want 250", r); end
  endtask

  task automatic test_muldiv();
    int gc, dc; logic [W-1:0] rr; logic ee;
    run_op(1, 2'b10, 8'd2, 8'd3, gc, dc, rr, ee);
    total++;
    if (gc < 0 || dc - gc !== 2) begin bad++; $display("FAIL mul_latency got %0d want 2", dc - gc); end
    total++;
    if (rr !== 8'd6 || ee !== 1'b0) begin bad++; $display("FAIL mul_result got r=%0d err=%b want 6,0", rr, ee); end
    run_op(1, 2'b11, 8'd6, 8'd3, gc, dc, rr, ee);
    total++;
    if (gc < 0 || dc - gc !== 8) begin bad++; $display("FAIL div_latency got %0d want 8", dc - gc); end
    total++;
    if (rr !== 8'd2 || ee !== 1'b0) begin bad++; $display("FAIL div_result got r=%0d err=%b want 2,0", rr, ee); end
    run_op(0, 2'b11, 8'd1, 8'd2, gc, dc, rr, ee);
    total++;
    if (rr !== 8'd126) begin bad++; $display("FAIL div_half got r=%0d want 126", rr); end
  endtask

  task automatic test_divzero();
    int gc, dc; logic [W-1:0] rr; logic ee;
    run_op(0, 2'b11, 8'd5, 8'd0, gc, dc, rr, ee);
    total++;
    if (dc < 0 || rr !== 8'd0 || ee !== 1'b1) begin bad++; $display("FAIL div0 got r=%0d err=%b done@%0d want 0,1", rr, ee, dc); end
    run_op(0, 2'b00, 8'd1, 8'd1, gc, dc, rr, ee);
    total++;
    if (rr !== 8'd2 || ee !== 1'b0) begin bad++; $display("FAIL after_div0 got r=%0d err=%b want 2,0", rr, ee); end
  endtask

  task automatic test_round_robin();
    int ids[$]; int ts[$];
    int both;
    both = 0;
    do_reset();
    op = 4'b0000; a = {8'd1, 8'd1}; b = {8'd1, 8'd1};
    req = 2'b11;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (gnt == 2'b11) both++;
      if (gnt[0]) begin req[0] = 1'b0; ids.push_back(0); ts.push_back(cyc); end
      if (gnt[1]) begin req[1] = 1'b0; ids.push_back(1); ts.push_back(cyc); end
      if (ids.size() == 2 && req == 2'b00 && ts[1] == cyc) req = 2'b11;
    end
    total++;
    if (ids.size() !== 4) begin
      bad++; $display("FAIL rr_count got %0d grants want 4", ids.size());
    end else begin
      total++;
      if (ids[0] !== 0 || ids[1] !== 1 || ids[2] !== 0 || ids[3] !== 1) begin
        bad++; $display("FAIL rr_order got %0d%0d%0d%0d want 0101", ids[0], ids[1], ids[2], ids[3]);
      end
      total++;
      if (ts[0] !== 1 || ts[1] !== 3 || ts[2] !== 5 || ts[3] !== 7) begin
        bad++; $display("FAIL rr_times got %0d,%0d,%0d,%0d want 1,3,5,7", ts[0], ts[1], ts[2], ts[3]);
      end
    end
    total++;
    if (both !== 0) begin bad++; $display("FAIL rr_onehot got %0d double grants want 0", both); end
  endtask

  task automatic test_reset_abort();
    int gc, dc, sawdone; logic [W-1:0] rr; logic ee;
    gc = -1; sawdone = 0;
    op[1:0] = 2'b11; a[7:0] = 8'd6; b[7:0] = 8'd3;
    req[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gnt[0]) begin gc = k; break; end
    end
    req[0] = 1'b0;
    total++;
    if (gc < 0) begin bad++; $display("FAIL abort_gnt got no gnt want gnt[0]"); end
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || r !== 8'd0 || done !== 2'b00) begin
      bad++; $display("FAIL abort_reset got busy=%b r=%0d done=%b want 0,0,00", busy, r, done);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done !== 2'b00) sawdone++;
    end
    total++;
    if (sawdone !== 0) begin bad++; $display("FAIL abort_nodone got %0d done cycles want 0", sawdone); end
    run_op(1, 2'b00, 8'd3, 8'd4, gc, dc, rr, ee);
    total++;
    if (gc !== 1 || dc !== 2 || rr !== 8'd7) begin
      bad++; $display("FAIL post_reset_req1 got gnt@%0d done@%0d r=%0d want 1,2,7", gc, dc, rr);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; a = '0; b = '0;
    test_reset();
    test_addsub();
    test_muldiv();
    test_divzero();
    test_round_robin();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
